program_counter: RTL and testbench

//   Program counter register of the pipelined MIPS datapath: holds the 16-bit

---
 rtl/mips_pkg.sv | 10 +
 rtl/dff_rstn.sv | 30 +++
 rtl/program_counter.sv | 48 ++++
 tb/tb_program_counter.sv | 106 ++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath address constants and types
// Used by the program counter, instruction memory and branch/jump adders.
package mips_pkg;

   localparam int ADDR_WIDTH = 16;
   localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = 16'h0000;

   typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage : mips_pkg

// File: rtl/dff_rstn.sv
// rtl/dff_rstn.sv - parameterised-width register, async active-low reset to INIT
// Shared by the program counter and the pipeline registers.
module dff_rstn #(
   parameter int               WIDTH = 1,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;

   always_comb begin
      data_d = d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= INIT;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule : dff_rstn

// File: rtl/program_counter.sv
// rtl/program_counter.sv - IF-stage program counter register
// Loads the upstream next-PC every rising edge; async reset returns to the boot address.
module program_counter #(
   parameter int                    ADDR_WIDTH = mips_pkg::ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = mips_pkg::RESET_ADDR
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] LoadValue,
   output logic [ADDR_WIDTH-1:0] OutputAddress
);

   logic [ADDR_WIDTH-1:0] pc_d;
   logic [ADDR_WIDTH-1:0] pc_q;

   // No enable or stall: the next-PC mux upstream decides everything.
   always_comb begin
      pc_d = LoadValue;
   end

   dff_rstn #(
      .WIDTH (ADDR_WIDTH),
      .INIT  (RESET_ADDR)
   ) u_pc_reg (
      .clk   (clock),
      .rst_n (reset),
      .d     (pc_d),
      .q     (pc_q)
   );

   assign OutputAddress = pc_q;

`ifndef SYNTHESIS
   logic seen_reset;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         seen_reset <= 1'b1;
      end
   end

   a_reset_value : assert property (@(posedge clock) !reset |-> (OutputAddress == RESET_ADDR));

   a_no_x_after_reset : assert property (@(posedge clock) disable iff (!reset)
      (seen_reset === 1'b1) |-> !$isunknown(OutputAddress));
`endif

endmodule : program_counter

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - directed self-checking bench for program_counter
module tb_program_counter;

   logic        clock;
   logic        reset;
   logic [15:0] LoadValue;
   logic [15:0] OutputAddress;

   int total = 0;
   int bad   = 0;

   program_counter dut (
      .clock         (clock),
      .reset         (reset),
      .LoadValue     (LoadValue),
      .OutputAddress (OutputAddress)
   );

   initial begin
      clock = 1'b0;
      forever #10 clock = ~clock;
   end

   task automatic check(input string tag, input logic [15:0] exp);
      total++;
      assert (OutputAddress === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, OutputAddress, exp);
      end
   endtask

   initial begin
      logic [15:0] v;

      // Reset held low for 100 ns: every edge must leave the PC at 0.
      reset     = 1'b0;
      LoadValue = 16'd40;
      repeat (5) begin
         @(posedge clock); #1;
         check("reset_hold", 16'd0);
      end

      // Release at t=100 between edges, then load 40 and 88.
      @(negedge clock);
      reset = 1'b1;
      #1 check("release_no_change", 16'd0);
      @(posedge clock); #1;
      check("load_40", 16'd40);
      @(negedge clock);
      LoadValue = 16'd88;
      #1 check("hold_40_between_edges", 16'd40);
      @(posedge clock); #1;
      check("load_88", 16'd88);

      // Async reset mid-cycle.
      @(negedge clock);
      reset = 1'b0;
      #1 check("async_reset_mid_cycle", 16'd0);
      @(posedge clock); #1;
      check("reset_ignores_edge", 16'd0);

      // Release with 666 pending: no change until the next edge.
      @(negedge clock);
      reset     = 1'b1;
      LoadValue = 16'd666;
      #1 check("release_666_waits", 16'd0);
      @(posedge clock); #1;
      check("load_666", 16'd666);

      // Reset asserted at the same instant as a rising edge.
      @(negedge clock);
      LoadValue = 16'd333;
      @(posedge clock);
      reset = 1'b0;
      #1 check("reset_wins_edge", 16'd0);
      @(negedge clock);
      reset = 1'b1;
      #1 check("release_333_waits", 16'd0);
      @(posedge clock); #1;
      check("load_333", 16'd333);

      // Extremes.
      @(negedge clock);
      LoadValue = 16'hFFFF;
      @(posedge clock); #1;
      check("load_ffff", 16'hFFFF);
      @(negedge clock);
      LoadValue = 16'h0001;
      #1 check("hold_ffff", 16'hFFFF);
      @(posedge clock); #1;
      check("load_0001", 16'h0001);

      // Random tracking: OutputAddress(n) == LoadValue(n-1).
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         v         = 16'($urandom);
         LoadValue = v;
         @(posedge clock); #1;
         check("random_track", v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_program_counter
